// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback,
// with a memory-ready watchdog and a retired-instruction counter.
module mips_mc_ctrl #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ir_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             iord,
  output logic             reg_write,
  output logic [1:0]       reg_dst,
  output logic [1:0]       wb_sel,
  output logic [1:0]       pc_src,
  output logic [1:0]       alu_op,
  output logic             illegal_op,
  output logic             mem_err,
  output logic             instr_done,
  output logic [CNT_W-1:0] retired,
  output logic [3:0]       state
);

  localparam int unsigned WD_W = 8;
  localparam bit          WD_EN = (TIMEOUT != 0);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  localparam logic [5:0] OP_ALU  = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  typedef enum logic [3:0] {
    S_RST     = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADDR = 4'd3,
    S_MEMRD   = 4'd4,
    S_MEMWB   = 4'd5,
    S_MEMWR   = 4'd6,
    S_EXEC    = 4'd7,
    S_ALUWB   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11,
    S_JAL     = 4'd12
  } state_t;

  state_t          state_q, state_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            wd_wait, wd_exp;
  logic            retire, illegal, timeout;

  logic            mem_read_d, mem_write_d, iord_d, reg_write_d;
  logic [1:0]      reg_dst_d, wb_sel_d, pc_src_d, alu_op_d;
  logic            pcw_d, pcw_q, fetch_d, fetch_q;

  // Watchdog only runs in states that wait on mem_ready
  assign wd_wait = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
  assign wd_exp  = WD_EN && wd_wait && !mem_ready && (wd_q == WD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RST;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
    end
  end

  // Next-state, watchdog and event decode
  always_comb begin
    state_d = state_q;
    wd_d    = wd_q;
    retire  = 1'b0;
    illegal = 1'b0;
    timeout = 1'b0;
    case (state_q)
      S_RST:   state_d = S_FETCH;
      S_FETCH: begin
        if (mem_ready) state_d = S_DECODE;
        else if (wd_exp) begin
          state_d = S_FETCH;
          timeout = 1'b1;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADDR;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_ALU:       state_d = S_EXEC;
          OP_J:         state_d = S_JUMP;
          OP_JAL:       state_d = S_JAL;
          default: begin
            state_d = S_FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      S_MEMADDR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD: begin
        if (mem_ready) state_d = S_MEMWB;
        else if (wd_exp) begin
          state_d = S_FETCH;
          timeout = 1'b1;
        end
      end
      S_MEMWR: begin
        if (mem_ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end else if (wd_exp) begin
          state_d = S_FETCH;
          timeout = 1'b1;
        end
      end
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_ADDIWB, S_JUMP, S_JAL: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      default: state_d = S_RST;
    endcase
    // Any state entry (including FETCH re-entry on timeout) restarts the count
    if ((state_d != state_q) || timeout) wd_d = '0;
    else if (wd_wait && !mem_ready) wd_d = wd_q + WD_W'(1);
  end

  // Moore outputs decoded from the upcoming state so they leave a flop
  always_comb begin
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    iord_d      = 1'b0;
    reg_write_d = 1'b0;
    reg_dst_d   = 2'd0;
    wb_sel_d    = 2'd0;
    pc_src_d    = 2'd0;
    alu_op_d    = 2'd0;
    pcw_d       = 1'b0;
    fetch_d     = 1'b0;
    case (state_d)
      S_FETCH: begin
        mem_read_d = 1'b1;
        fetch_d    = 1'b1;
      end
      S_MEMRD: begin
        mem_read_d = 1'b1;
        iord_d     = 1'b1;
      end
      S_MEMWB: begin
        reg_write_d = 1'b1;
        wb_sel_d    = 2'd1;
      end
      S_MEMWR: begin
        mem_write_d = 1'b1;
        iord_d      = 1'b1;
      end
      S_EXEC:   alu_op_d = 2'd1;
      S_ALUWB: begin
        reg_write_d = 1'b1;
        reg_dst_d   = 2'd1;
      end
      S_ADDIWB: reg_write_d = 1'b1;
      S_JUMP: begin
        pcw_d    = 1'b1;
        pc_src_d = 2'd1;
      end
      S_JAL: begin
        pcw_d       = 1'b1;
        pc_src_d    = 2'd2;
        reg_write_d = 1'b1;
        reg_dst_d   = 2'd2;
        wb_sel_d    = 2'd2;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      iord       <= 1'b0;
      reg_write  <= 1'b0;
      reg_dst    <= 2'd0;
      wb_sel     <= 2'd0;
      pc_src     <= 2'd0;
      alu_op     <= 2'd0;
      pcw_q      <= 1'b0;
      fetch_q    <= 1'b0;
      illegal_op <= 1'b0;
      mem_err    <= 1'b0;
      instr_done <= 1'b0;
      retired    <= '0;
    end else begin
      mem_read   <= mem_read_d;
      mem_write  <= mem_write_d;
      iord       <= iord_d;
      reg_write  <= reg_write_d;
      reg_dst    <= reg_dst_d;
      wb_sel     <= wb_sel_d;
      pc_src     <= pc_src_d;
      alu_op     <= alu_op_d;
      pcw_q      <= pcw_d;
      fetch_q    <= fetch_d;
      illegal_op <= illegal;
      mem_err    <= timeout;
      instr_done <= retire;
      if (retire) retired <= retired + CNT_W'(1);
    end
  end

  // IR/PC load in FETCH only happens on the cycle memory delivers the word
  assign ir_write = fetch_q & mem_ready;
  assign pc_write = pcw_q | (fetch_q & mem_ready);
  assign state    = state_q;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Self-checking bench for mips_mc_ctrl: directed scenarios with literal
// expectations followed by randomized traffic against an instruction-level model.
module tb_mips_mc_ctrl;

  localparam int unsigned TO = 4;
  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [5:0]    opcode;
  logic          mem_ready;
  logic          pc_write, ir_write, mem_read, mem_write, iord, reg_write;
  logic [1:0]    reg_dst, wb_sel, pc_src, alu_op;
  logic          illegal_op, mem_err, instr_done;
  logic [CW-1:0] retired;
  logic [3:0]    state;

  int n_cmp = 0;
  int n_bad = 0;

  mips_mc_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .mem_read(mem_read),
    .mem_write(mem_write), .iord(iord), .reg_write(reg_write),
    .reg_dst(reg_dst), .wb_sel(wb_sel), .pc_src(pc_src), .alu_op(alu_op),
    .illegal_op(illegal_op), .mem_err(mem_err), .instr_done(instr_done),
    .retired(retired), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- instruction-level reference model ----------------
  int            m_state;
  int            m_wait;
  int            m_path[$];
  logic [CW-1:0] m_ret;
  bit            m_done, m_ill, m_err;

  // Expected strobes per state:
  // {mem_read, mem_write, iord, reg_write, reg_dst, wb_sel, pc_src, alu_op, pc_write}
  function automatic logic [12:0] row(input int s);
    case (s)
      1:       row = 13'b1_0_0_0_00_00_00_00_0;
      4:       row = 13'b1_0_1_0_00_00_00_00_0;
      5:       row = 13'b0_0_0_1_00_01_00_00_0;
      6:       row = 13'b0_1_1_0_00_00_00_00_0;
      7:       row = 13'b0_0_0_0_00_00_00_01_0;
      8:       row = 13'b0_0_0_1_01_00_00_00_0;
      10:      row = 13'b0_0_0_1_00_00_00_00_0;
      11:      row = 13'b0_0_0_0_00_00_01_00_1;
      12:      row = 13'b0_0_0_1_10_10_10_00_1;
      default: row = 13'b0;
    endcase
  endfunction

  task automatic m_reset();
    m_state = 0;
    m_wait  = 0;
    m_path.delete();
    m_ret   = '0;
    m_done  = 1'b0;
    m_ill   = 1'b0;
    m_err   = 1'b0;
  endtask

  task automatic m_enter(input int s);
    m_state = s;
    m_wait  = 0;
  endtask

  // Pops the next step of the instruction, or retires it when none remain
  task automatic m_advance(output bit done);
    done = 1'b0;
    if (m_path.size() > 0) m_enter(m_path.pop_front());
    else begin
      done = 1'b1;
      m_enter(1);
    end
  endtask

  task automatic m_step();
    bit nd, ni, ne;
    nd = 1'b0; ni = 1'b0; ne = 1'b0;
    case (m_state)
      0: m_enter(1);
      1, 4, 6: begin
        if (mem_ready) begin
          if (m_state == 1) m_enter(2);
          else m_advance(nd);
        end else if (TO != 0 && m_wait + 1 == int'(TO)) begin
          m_path.delete();
          ne = 1'b1;
          m_enter(1);
        end else m_wait++;
      end
      2: begin
        m_path.delete();
        case (opcode)
          6'h23: begin m_path.push_back(3); m_path.push_back(4); m_path.push_back(5); end
          6'h2B: begin m_path.push_back(3); m_path.push_back(6); end
          6'h08: begin m_path.push_back(9); m_path.push_back(10); end
          6'h00: begin m_path.push_back(7); m_path.push_back(8); end
          6'h02: m_path.push_back(11);
          6'h03: m_path.push_back(12);
          default: ;
        endcase
        if (m_path.size() == 0) begin
          ni = 1'b1;
          m_enter(1);
        end else m_enter(m_path.pop_front());
      end
      default: m_advance(nd);
    endcase
    m_done = nd;
    m_ill  = ni;
    m_err  = ne;
    if (nd) m_ret = m_ret + CW'(1);
  endtask

  task automatic check_cycle();
    logic [12:0] r, ex, act;
    bit fr;
    fr  = (m_state == 1) && mem_ready;
    r   = row(m_state);
    ex  = {r[12:1], r[0] | fr};
    act = {mem_read, mem_write, iord, reg_write, reg_dst, wb_sel, pc_src, alu_op, pc_write};
    chk("state", 32'(state), 32'(m_state));
    chk("ctrl", 32'(act), 32'(ex));
    chk("ir_write", 32'(ir_write), 32'(fr));
    chk("pulses", 32'({illegal_op, mem_err, instr_done}), 32'({m_ill, m_err, m_done}));
    chk("retired", 32'(retired), 32'(m_ret));
  endtask

  // Compare process: checks mid-cycle, then advances the model over the next edge
  initial begin
    m_reset();
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_reset();
        check_cycle();
      end else begin
        check_cycle();
        m_step();
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [5:0] pick_op();
    logic [5:0] op;
    case ($urandom_range(0, 6))
      0: op = 6'h00;
      1: op = 6'h02;
      2: op = 6'h03;
      3: op = 6'h08;
      4: op = 6'h23;
      5: op = 6'h2B;
      default: begin
        op = 6'($urandom_range(0, 63));
        while (op inside {6'h00, 6'h02, 6'h03, 6'h08, 6'h23, 6'h2B})
          op = 6'($urandom_range(0, 63));
      end
    endcase
    return op;
  endfunction

  initial begin
    logic [23:0] sq;
    int mw, rw, dn, pct;
    rst_n = 1'b0; opcode = 6'h00; mem_ready = 1'b0;
    repeat (3) tick();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_retired", 32'(retired), 32'd0);

    // LW with memory always ready: 1,2,3,4,5,1
    rst_n = 1'b1; mem_ready = 1'b1; opcode = 6'h23;
    sq = '0; dn = 0; rw = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      sq = {sq[19:0], state};
      dn += int'(instr_done);
      if (i == 4) rw = int'({reg_write, wb_sel} == 3'b101);
    end
    chk("lw_seq", 32'(sq), 32'h123451);
    chk("lw_wb", 32'(rw), 32'd1);
    chk("lw_done", 32'(dn), 32'd1);
    chk("lw_retired", 32'(retired), 32'd1);

    // SW with three wait cycles in MEMWR
    opcode = 6'h2B; mw = 0; rw = 0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (i == 1) mem_ready = 1'b0;
      if (i == 5) mem_ready = 1'b1;
      mw += int'(mem_write);
      rw += int'(reg_write);
    end
    chk("sw_memwrite_cycles", 32'(mw), 32'd4);
    chk("sw_no_regwrite", 32'(rw), 32'd0);
    chk("sw_state", 32'(state), 32'd1);
    chk("sw_retired", 32'(retired), 32'd2);

    // JAL
    opcode = 6'h03;
    tick(); tick();
    chk("jal_state", 32'(state), 32'd12);
    chk("jal_ctl", 32'({pc_write, pc_src, reg_dst, wb_sel}), 32'b1_10_10_10);
    tick();
    chk("jal_fetch", 32'(state), 32'd1);
    chk("jal_retired", 32'(retired), 32'd3);

    // Illegal opcode
    opcode = 6'h3F;
    tick();
    chk("ill_decode_pcw", 32'(pc_write), 32'd0);
    tick();
    chk("ill_pulse", 32'({state, illegal_op}), 32'({4'd1, 1'b1}));
    chk("ill_retired", 32'(retired), 32'd3);
    opcode = 6'h23;
    tick();
    chk("ill_one_cycle", 32'(illegal_op), 32'd0);

    // LW timeout in MEMRD after four idle cycles
    tick();
    mem_ready = 1'b0; rw = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      rw += int'(reg_write);
    end
    chk("to_state", 32'(state), 32'd1);
    chk("to_err", 32'(mem_err), 32'd1);
    chk("to_no_regwrite", 32'(rw), 32'd0);
    chk("to_retired", 32'(retired), 32'd3);
    mem_ready = 1'b1;
    tick();
    chk("to_err_clear", 32'(mem_err), 32'd0);
    // Ready on the expiry cycle wins
    mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("edge_in_memrd", 32'(state), 32'd4);
    mem_ready = 1'b1;
    tick();
    chk("edge_memwb", 32'({state, mem_err}), 32'({4'd5, 1'b0}));
    tick();
    chk("edge_retired", 32'(retired), 32'd4);

    // Asynchronous reset during EXEC
    opcode = 6'h00;
    tick(); tick();
    chk("exec_state", 32'({state, alu_op}), 32'({4'd7, 2'd1}));
    #1 rst_n = 1'b0;
    #1;
    chk("async_outs", 32'({pc_write, ir_write, mem_read, mem_write, iord, reg_write,
                          reg_dst, wb_sel, pc_src, alu_op, illegal_op, mem_err, instr_done}), 32'd0);
    chk("async_state", 32'({state, retired}), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_fetch", 32'(state), 32'd1);

    // Randomized traffic; opcode only changes while the model is in FETCH
    for (int c = 0; c < 6000; c++) begin
      tick();
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 1499) == 0) rst_n = 1'b0;
      if (c < 1500) pct = 100;
      else if ((c / 500) % 3 == 0) pct = 85;
      else if ((c / 500) % 3 == 1) pct = 40;
      else pct = 10;
      mem_ready = ($urandom_range(0, 99) < pct);
      if (m_state == 1) opcode = pick_op();
    end
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mips_mc_ctrl.md
Name: mips_mc_ctrl

Overview:
- Multi-cycle control FSM for the MIPS datapath.
- Sequences fetch, decode, execute, memory and writeback for LW, SW, ADDI, J, JAL and R-type instructions.
- Drives the PC-source select that feeds the next-PC/ALU-result mux, plus the register-file and memory strobes.
- Handles a ready handshake to instruction/data memory, with a timeout watchdog and a retired-instruction counter.

Parameters:
- TIMEOUT, 255: max cycles to wait for mem_ready in a memory state; 0 disables the watchdog. Range 0..255.
- CNT_W, 32: width of retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- opcode  input  6  IR[31:26], valid from DECODE onward
- mem_ready  input  1  memory completes the current read/write this cycle
- pc_write  output  1  load PC
- ir_write  output  1  load IR from memory data
- mem_read  output  1  memory read request (held until mem_ready)
- mem_write  output  1  memory write request (held until mem_ready)
- iord  output  1  0 = address from PC, 1 = address from ALUOut
- reg_write  output  1  register-file write enable
- reg_dst  output  2  0 = rt, 1 = rd, 2 = $31
- wb_sel  output  2  0 = ALUOut, 1 = MDR, 2 = PC+4
- pc_src  output  2  0 = PC+4, 1 = jump target, 2 = JAL target
- alu_op  output  2  0 = add, 1 = funct-decoded (R-type)
- illegal_op  output  1  one-cycle pulse on unsupported opcode
- mem_err  output  1  one-cycle pulse on watchdog expiry
- instr_done  output  1  one-cycle pulse when an instruction retires
- retired  output  CNT_W  count of retired instructions, wraps
- state  output  4  current state encoding, for debug

Behaviour:
- Opcodes: ALU = 6'h00, J = 6'h02, JAL = 6'h03, ADDI = 6'h08, LW = 6'h23, SW = 6'h2B.
- Reset (rst_n low, async): state = RST (0), all outputs 0, retired = 0, watchdog = 0. On the first clock after release, go RST -> FETCH unconditionally.
- Outputs are Moore, decoded from the state register only. Pulses (illegal_op, mem_err, instr_done) are registered, asserted the cycle after the causing transition, and last exactly one cycle.
- FETCH (1):
  - Asserts mem_read, iord = 0, ir_write, pc_write, pc_src = 0. ir_write and pc_write are qualified by mem_ready.
  - Stays in FETCH until mem_ready = 1, then goes to DECODE.
- DECODE (2): alu_op = 0, no strobes. Next state by opcode:
  - LW or SW -> MEMADDR
  - ADDI -> ADDIEX
  - ALU -> EXEC
  - J -> JUMP
  - JAL -> JAL
  - any other -> FETCH with illegal_op; no retire, no PC write.
- MEMADDR (3): alu_op = 0. LW -> MEMRD; SW -> MEMWR.
- MEMRD (4): mem_read, iord = 1. On mem_ready -> MEMWB.
- MEMWB (5): reg_write, reg_dst = 0, wb_sel = 1 -> FETCH, retire.
- MEMWR (6): mem_write, iord = 1. On mem_ready -> FETCH, retire.
- EXEC (7): alu_op = 1 -> ALUWB.
- ALUWB (8): reg_write, reg_dst = 1, wb_sel = 0 -> FETCH, retire.
- ADDIEX (9): alu_op = 0 -> ADDIWB.
- ADDIWB (10): reg_write, reg_dst = 0, wb_sel = 0 -> FETCH, retire.
- JUMP (11): pc_write, pc_src = 1 -> FETCH, retire.
- JAL (12): pc_write, pc_src = 2, reg_write, reg_dst = 2, wb_sel = 2 -> FETCH, retire.
- Retire: instr_done pulses and retired increments by 1, wrapping from all-ones to 0.
- Watchdog:
  - An 8-bit counter is cleared on entry to FETCH, MEMRD or MEMWR.
  - It increments each cycle the FSM stays in that state with mem_ready = 0.
  - When it reaches TIMEOUT, drop the request and go to FETCH with mem_err. No retire, no PC/IR/register write.
  - Exception: a timeout in FETCH re-enters FETCH, refetching the same PC.
  - If mem_ready = 1 on the same cycle the counter reaches TIMEOUT, mem_ready wins: normal advance, no mem_err.
- Timing: mem_ready is sampled only in FETCH, MEMRD and MEMWR; it is ignored elsewhere. opcode is sampled only in DECODE and MEMADDR.
- Reset mid-instruction: the FSM aborts immediately to RST, outputs go low asynchronously, and the counter clears.
- Latency with mem_ready held high, in cycles:
  - J = 3
  - JAL = 3
  - R-type = 4
  - ADDI = 4
  - SW = 4
  - LW = 5
  - Each wait cycle in a memory state adds 1.

Test Plan:
- Reset then mem_ready = 1, opcode = 6'h23 -> states 1,2,3,4,5,1. reg_write with wb_sel = 1 in cycle 5; instr_done once; retired = 1.
- opcode = 6'h2B, mem_ready low for 3 cycles in MEMWR -> mem_write held 4 cycles; no reg_write; retire after mem_ready; 7 cycles total.
- opcode = 6'h03 -> cycle 3 has pc_write = 1, pc_src = 2, reg_dst = 2, wb_sel = 2; then FETCH.
- opcode = 6'h3F -> DECODE then FETCH; illegal_op pulses once; retired unchanged; no pc_write outside FETCH.
- TIMEOUT = 4, mem_ready = 0 in MEMRD -> after 4 wait cycles, mem_err pulses, FSM in FETCH, reg_write never asserted. Repeat with mem_ready = 1 on the 4th cycle -> MEMWB, no mem_err.
- rst_n pulsed low during EXEC -> outputs 0 within the same cycle, state = 0, retired = 0; FETCH one clock after release.
